// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Request fields are carried at the widest supported address width; the arbiter slices to its own width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DMEM_AW_MAX = 32;

  typedef struct packed {
    logic                   we;
    logic [DMEM_AW_MAX-1:0] addr;
    logic [31:0]            wdata;
    logic [2:0]             funct3;
  } dmem_req_t;

  // Zeroes a request unless it is the one being forwarded to the memory.
  function automatic dmem_req_t req_gate(input dmem_req_t r, input logic en);
    dmem_req_t g;
    g = '0;
    if (en) begin
      g = r;
    end else begin
      g = '0;
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant.
// The priority pointer moves to the loser after every grant; reset and hold suppress all grants.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hold_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;
  logic [1:0] gnt_s;

  always_comb begin
    gnt_s  = 2'b00;
    prio_d = prio_q;
    if (rst_i || hold_i) begin
      gnt_s = 2'b00;
    end else begin
      case (req_i)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = prio_q ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
    if (gnt_s[0]) begin
      prio_d = 1'b1;
    end else if (gnt_s[1]) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign gnt_o = gnt_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the load/store path (port 0) and the debug loader (port 1).
// One grant per cycle; memory controls are combinational, the response is registered one cycle later.
module dmem_arbiter #(
  parameter int AddressWidth = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    hold_i,
  input  logic                    req0_valid_i,
  input  logic                    req0_we_i,
  input  logic [AddressWidth-1:0] req0_addr_i,
  input  logic [31:0]             req0_wdata_i,
  input  logic [2:0]              req0_funct3_i,
  input  logic                    req1_valid_i,
  input  logic                    req1_we_i,
  input  logic [AddressWidth-1:0] req1_addr_i,
  input  logic [31:0]             req1_wdata_i,
  input  logic [2:0]              req1_funct3_i,
  output logic                    req0_ready_o,
  output logic                    req1_ready_o,
  output logic                    rsp0_valid_o,
  output logic                    rsp1_valid_o,
  output logic [31:0]             rsp0_rdata_o,
  output logic [31:0]             rsp1_rdata_o,
  output logic                    mem_r_en_o,
  output logic                    mem_wr_en_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [31:0]             mem_wr_data_o,
  output logic [2:0]              mem_funct3_o,
  input  logic [31:0]             mem_r_data_i
);

  import dmem_pkg::*;

  logic [1:0]  gnt_s;
  logic        granted_s;
  dmem_req_t   req0_s;
  dmem_req_t   req1_s;
  dmem_req_t   sel_s;

  logic [1:0]  rsp_valid_q;
  logic [1:0]  rsp_valid_d;
  logic [31:0] rsp_rdata_q;
  logic [31:0] rsp_rdata_d;

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .hold_i (hold_i),
    .req_i  ({req1_valid_i, req0_valid_i}),
    .gnt_o  (gnt_s)
  );

  assign granted_s = |gnt_s;

  always_comb begin
    req0_s                         = '0;
    req0_s.we                      = req0_we_i;
    req0_s.addr[AddressWidth-1:0]  = req0_addr_i;
    req0_s.wdata                   = req0_wdata_i;
    req0_s.funct3                  = req0_funct3_i;
    req1_s                         = '0;
    req1_s.we                      = req1_we_i;
    req1_s.addr[AddressWidth-1:0]  = req1_addr_i;
    req1_s.wdata                   = req1_wdata_i;
    req1_s.funct3                  = req1_funct3_i;
  end

  always_comb begin
    sel_s = '0;
    if (gnt_s[0]) begin
      sel_s = req_gate(req0_s, 1'b1);
    end else if (gnt_s[1]) begin
      sel_s = req_gate(req1_s, 1'b1);
    end else begin
      sel_s = '0;
    end
  end

  // Address bits above AddressWidth are always zero padding.
  if (AddressWidth < DMEM_AW_MAX) begin : g_addr_pad
    logic unused_addr_pad_s;
    assign unused_addr_pad_s = ^sel_s.addr[DMEM_AW_MAX-1:AddressWidth];
  end

  assign req0_ready_o  = gnt_s[0];
  assign req1_ready_o  = gnt_s[1];
  assign mem_r_en_o    = granted_s & ~sel_s.we;
  assign mem_wr_en_o   = granted_s & sel_s.we;
  assign mem_addr_o    = sel_s.addr[AddressWidth-1:0];
  assign mem_wr_data_o = sel_s.wdata;
  assign mem_funct3_o  = sel_s.funct3;

  always_comb begin
    rsp_valid_d = gnt_s;
    rsp_rdata_d = rsp_rdata_q;
    if (granted_s) begin
      rsp_rdata_d = sel_s.we ? 32'h0000_0000 : mem_r_data_i;
    end else begin
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Strobes are masked during reset so a grant just before reset is never acknowledged.
  assign rsp0_valid_o = rsp_valid_q[0] & ~rst_i;
  assign rsp1_valid_o = rsp_valid_q[1] & ~rst_i;
  assign rsp0_rdata_o = rsp_rdata_q;
  assign rsp1_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory and a response scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 10;

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic [31:0] data;
  } rsp_exp_t;

  logic clk, rst, hold;
  logic v0, we0, v1, we1;
  logic [AW-1:0] a0, a1;
  logic [31:0] d0, d1;
  logic [2:0] f0, f1;
  logic ready0, ready1, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic mem_r_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wr_data, mem_r_data;
  logic [2:0] mem_funct3;

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  rsp_exp_t exp_q[$];
  int n_vec, n_err;
  logic prio_m;
  logic [31:0] last_data;

  dmem_arbiter #(.AddressWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold),
    .req0_valid_i(v0), .req0_we_i(we0), .req0_addr_i(a0), .req0_wdata_i(d0), .req0_funct3_i(f0),
    .req1_valid_i(v1), .req1_we_i(we1), .req1_addr_i(a1), .req1_wdata_i(d1), .req1_funct3_i(f1),
    .req0_ready_o(ready0), .req1_ready_o(ready1),
    .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid),
    .rsp0_rdata_o(rsp0_rdata), .rsp1_rdata_o(rsp1_rdata),
    .mem_r_en_o(mem_r_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
    .mem_wr_data_o(mem_wr_data), .mem_funct3_o(mem_funct3), .mem_r_data_i(mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      F3_B:    return {{24{w[7]}}, w[7:0]};
      F3_H:    return {{16{w[15]}}, w[15:0]};
      F3_W:    return w;
      F3_BU:   return {24'h0, w[7:0]};
      F3_HU:   return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] wr_fn(input logic [31:0] w, input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      F3_B:    return {w[31:8], d[7:0]};
      F3_H:    return {w[31:16], d[15:0]};
      F3_W:    return d;
      default: return w;
    endcase
  endfunction

  assign mem_r_data = mem_r_en ? rd_fn(mem[mem_addr], mem_funct3) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic p0(input logic v, input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] f);
    v0 = v; we0 = we; a0 = a; d0 = d; f0 = f;
  endtask

  task automatic p1(input logic v, input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] f);
    v1 = v; we1 = we; a1 = a; d1 = d; f1 = f;
  endtask

  // One clock: check last cycle's response and this cycle's grant, then advance the models.
  task automatic step();
    rsp_exp_t e;
    logic g0, g1, gwe, dwe;
    logic [AW-1:0] ga, da;
    logic [31:0] gwd, dd, rd;
    logic [2:0] gf, df;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp0_valid", 32'(rsp0_valid), 32'(e.v0 & ~rst));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(e.v1 & ~rst));
      chk("rsp0_rdata", rsp0_rdata, e.data);
      chk("rsp1_rdata", rsp1_rdata, e.data);
    end
    g0 = !rst && !hold && v0 && (!v1 || !prio_m);
    g1 = !rst && !hold && v1 && (!v0 || prio_m);
    chk("ready0", 32'(ready0), 32'(g0));
    chk("ready1", 32'(ready1), 32'(g1));
    gwe = g0 ? we0 : (g1 ? we1 : 1'b0);
    ga  = g0 ? a0  : (g1 ? a1  : '0);
    gwd = g0 ? d0  : (g1 ? d1  : 32'h0);
    gf  = g0 ? f0  : (g1 ? f1  : 3'b000);
    chk("mem_r_en", 32'(mem_r_en), 32'((g0 | g1) & ~gwe));
    chk("mem_wr_en", 32'(mem_wr_en), 32'((g0 | g1) & gwe));
    chk("mem_addr", 32'(mem_addr), 32'(ga));
    chk("mem_wdata", mem_wr_data, gwd);
    chk("mem_funct3", 32'(mem_funct3), 32'(gf));
    rd  = ((g0 | g1) && !gwe) ? rd_fn(ref_mem[ga], gf) : 32'h0;
    dwe = mem_wr_en; da = mem_addr; dd = mem_wr_data; df = mem_funct3;
    @(posedge clk);
    #1;
    if (dwe) mem[da] = wr_fn(mem[da], dd, df);
    if ((g0 | g1) && gwe) ref_mem[ga] = wr_fn(ref_mem[ga], gwd, gf);
    e = '0;
    if (rst) begin
      prio_m = 1'b0;
      last_data = 32'h0;
    end else begin
      if (g0 | g1) last_data = rd;
      e.v0 = g0;
      e.v1 = g1;
      if (g0) prio_m = 1'b1;
      else if (g1) prio_m = 1'b0;
    end
    e.data = last_data;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [2:0] f3_tab [5];
    f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    n_vec = 0; n_err = 0; prio_m = 1'b0; last_data = 32'h0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[3] = 32'h1122_3344;
    ref_mem[3] = 32'h1122_3344;
    rst = 1'b1; hold = 1'b0;
    p0(1'b0, 1'b0, 10'd0, 32'h0, 3'b000);
    p1(1'b0, 1'b0, 10'd0, 32'h0, 3'b000);
    step(); step();
    rst = 1'b0;

    // Store then load same word from port 0
    p0(1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, F3_W); step();
    p0(1'b1, 1'b0, 10'd5, 32'h0, F3_W); step();
    p0(1'b0, 1'b0, 10'd0, 32'h0, 3'b000); step();

    // Both ports loading continuously from reset
    rst = 1'b1; step(); rst = 1'b0;
    p0(1'b1, 1'b0, 10'd5, 32'h0, F3_W);
    p1(1'b1, 1'b0, 10'd3, 32'h0, F3_W);
    for (int i = 0; i < 6; i++) step();
    p0(1'b0, 1'b0, 10'd0, 32'h0, 3'b000);
    p1(1'b0, 1'b0, 10'd0, 32'h0, 3'b000); step();

    // Byte store and sign/zero-extending byte loads from port 1
    p1(1'b1, 1'b1, 10'd3, 32'h0000_00A5, F3_B); step();
    p1(1'b1, 1'b0, 10'd3, 32'h0, F3_B); step();
    p1(1'b1, 1'b0, 10'd3, 32'h0, F3_BU); step();
    p1(1'b0, 1'b0, 10'd0, 32'h0, 3'b000); step();

    // Hold freeze with both valid
    p0(1'b1, 1'b0, 10'd5, 32'h0, F3_H);
    p1(1'b1, 1'b0, 10'd3, 32'h0, F3_HU);
    hold = 1'b1; step(); step(); step();
    hold = 1'b0; step(); step();
    p0(1'b0, 1'b0, 10'd0, 32'h0, 3'b000);
    p1(1'b0, 1'b0, 10'd0, 32'h0, 3'b000); step();

    // Reset right after a port 0 load grant, with a port 1 store pending
    p0(1'b1, 1'b0, 10'd5, 32'h0, F3_W); step();
    p0(1'b0, 1'b0, 10'd0, 32'h0, 3'b000);
    p1(1'b1, 1'b1, 10'd7, 32'h1234_5678, F3_W);
    rst = 1'b1; step(); rst = 1'b0;
    p0(1'b1, 1'b0, 10'd5, 32'h0, F3_W);
    p1(1'b1, 1'b0, 10'd7, 32'h0, F3_W); step();
    p0(1'b0, 1'b0, 10'd0, 32'h0, 3'b000); step();
    p1(1'b0, 1'b0, 10'd0, 32'h0, 3'b000); step();

    // Unsupported funct3 load and store
    p0(1'b1, 1'b0, 10'd5, 32'h0, 3'b011); step();
    p0(1'b1, 1'b1, 10'd5, 32'hFFFF_FFFF, 3'b011); step();
    p0(1'b1, 1'b0, 10'd5, 32'h0, F3_W); step();
    p0(1'b0, 1'b0, 10'd0, 32'h0, 3'b000); step();

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      hold = ($urandom_range(0, 7) == 0);
      p0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
         $urandom, f3_tab[$urandom_range(0, 4)]);
      p1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
         $urandom, f3_tab[$urandom_range(0, 4)]);
      step();
    end
    hold = 1'b0;
    p0(1'b0, 1'b0, 10'd0, 32'h0, 3'b000);
    p1(1'b0, 1'b0, 10'd0, 32'h0, 3'b000);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
